param_gray_counter: RTL

PARAM_GRAY_COUNTER -- requirements
Module: param_gray_counter

---
 rtl/param_gray_counter.sv | 59 +++++
 1 files changed

// File: rtl/param_gray_counter.sv
// Up/down binary counter with a registered Gray-coded copy and a terminal-count flag.
// The counter either wraps or holds at the ends of its range, selected by SATURATE.
module param_gray_counter #(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc
);
  localparam logic [WIDTH-1:0] MAX_V = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam bit               SAT   = (SATURATE != 0);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;
  logic             at_bound;

  always_comb begin
    at_bound = up_dn ? (bin_q == MAX_V) : (bin_q == '0);
    bin_d    = bin_q;
    tc_d     = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (at_bound) begin
        tc_d  = 1'b1;
        bin_d = SAT ? bin_q : (up_dn ? '0 : MAX_V);
      end else begin
        bin_d = up_dn ? bin_q + ONE : bin_q - ONE;
      end
    end
    // Gray is derived from the next binary value so both registers move on the same edge.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign tc       = tc_q;
endmodule
